data_mem_responder: RTL and testbench

Data-memory responder for the pipelined processor's data port. It serves single-word reads and writes from the Memory stage. It holds `DataWaitreq` high for a programmable number of wait states, then completes the access in one cycle: read data is presented on `DataIn`, or write data is committed. Reads and writes to unmapped addresses are flagged, and stall cycles are counted for performance work.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/sp_ram.sv | 26 ++
 rtl/data_mem_responder.sv | 117 +++++++++++
 tb/tb_data_mem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the data-memory responder.
`default_nettype none

package mem_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Request latch; field widths follow the package WORD_SIZE.
  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
    logic                 is_read;
    logic                 is_err;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous RAM with one write enable and registered read data.
`default_nettype none

module sp_ram #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 12
) (
  input  logic                  Clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  // rdata only moves on a read, so it holds between accesses.
  always_ff @(posedge Clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data-memory slave with bus-error flag and stall counter.
`default_nettype none

module data_mem_responder
  import mem_pkg::mem_state_t, mem_pkg::mem_req_t, mem_pkg::IDLE, mem_pkg::WAIT, mem_pkg::DONE;
#(
  parameter int WORD_SIZE  = mem_pkg::WORD_SIZE,
  parameter int ADDR_BITS  = 12,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic                 BusError,
  output logic [WORD_SIZE-1:0] StallCount
);

  localparam logic [3:0] READ_LOAD  = 4'(READ_WAIT - 1);
  localparam logic [3:0] WRITE_LOAD = 4'(WRITE_WAIT - 1);

  mem_state_t           state;
  mem_req_t             req_q;
  logic [3:0]           wait_cnt;
  logic                 data_zero;
  logic [WORD_SIZE-1:0] ram_q;

  logic                 request;
  logic                 illegal;
  logic [WORD_SIZE-1:0] addr_mux;
  logic                 unmapped;
  logic                 cur_read;
  logic [3:0]           load_val;
  logic                 last_wait;
  logic                 ram_we;
  logic                 ram_re;

  assign request = ReadData ^ WriteData;
  assign illegal = ReadData & WriteData;

  // In IDLE the live inputs describe the access; afterwards only the latched copy counts.
  assign addr_mux = (state == IDLE) ? DataAddr : req_q.addr;
  assign cur_read = (state == IDLE) ? ReadData : req_q.is_read;
  assign unmapped = |addr_mux[WORD_SIZE-1:ADDR_BITS];
  assign load_val = ReadData ? READ_LOAD : WRITE_LOAD;

  // Final waitreq cycle: a one-wait access skips WAIT and goes straight to DONE.
  assign last_wait = ((state == IDLE) && request && (load_val == 4'd0)) ||
                     ((state == WAIT) && (wait_cnt == 4'd1));

  assign ram_re = last_wait && cur_read && !unmapped && !Reset;
  assign ram_we = (state == DONE) && !req_q.is_read && !req_q.is_err && !Reset;

  assign DataWaitreq = !Reset && (((state == IDLE) && request) || (state == WAIT));
  assign DataIn      = data_zero ? '0 : ram_q;

  sp_ram #(
    .WIDTH      (WORD_SIZE),
    .DEPTH_BITS (ADDR_BITS)
  ) u_ram (
    .Clock (Clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_mux[ADDR_BITS-1:0]),
    .wdata (req_q.wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      req_q      <= '0;
      wait_cnt   <= 4'd0;
      data_zero  <= 1'b1;
      BusError   <= 1'b0;
      StallCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (illegal) begin
            BusError  <= 1'b1;
            data_zero <= 1'b1;
          end else if (request) begin
            req_q.addr    <= DataAddr;
            req_q.wdata   <= DataOut;
            req_q.is_read <= ReadData;
            req_q.is_err  <= unmapped;
            wait_cnt      <= load_val;
            state         <= (load_val == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= DONE;
        end
        DONE: begin
          if (req_q.is_err) BusError <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Unmapped reads return zero rather than whatever the RAM last produced.
      if (last_wait && cur_read) data_zero <= unmapped;

      if (DataWaitreq && (StallCount != '1)) StallCount <= StallCount + WORD_SIZE'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus queues expected completions, a monitor checks them as they appear.
`default_nettype none

module tb_data_mem_responder;

  logic        Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset;
  logic [15:0] DataAddr, DataOut;
  logic        ReadData, WriteData;
  logic [15:0] DataIn, StallCount;
  logic        DataWaitreq, BusError;

  logic        s_Reset;
  logic [15:0] s_DataAddr, s_DataOut;
  logic        s_ReadData, s_WriteData;
  logic [15:0] s_DataIn, s_StallCount;
  logic        s_DataWaitreq, s_BusError;

  data_mem_responder #(
    .WORD_SIZE(16), .ADDR_BITS(12), .READ_WAIT(2), .WRITE_WAIT(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(ReadData), .WriteData(WriteData), .DataIn(DataIn),
    .DataWaitreq(DataWaitreq), .BusError(BusError), .StallCount(StallCount)
  );

  // Long-wait instance used only to drive the stall counter into saturation.
  data_mem_responder #(
    .WORD_SIZE(16), .ADDR_BITS(12), .READ_WAIT(15), .WRITE_WAIT(15)
  ) dut_sat (
    .Clock(Clock), .Reset(s_Reset), .DataAddr(s_DataAddr), .DataOut(s_DataOut),
    .ReadData(s_ReadData), .WriteData(s_WriteData), .DataIn(s_DataIn),
    .DataWaitreq(s_DataWaitreq), .BusError(s_BusError), .StallCount(s_StallCount)
  );

  typedef struct {
    logic [15:0] data;
    bit          chk;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (!Reset && (ReadData || WriteData) && !DataWaitreq) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got completion at %0t expected none", $time);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) check("read_data", DataIn, e.data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input int exp_waits,
                        input logic [15:0] exp_data, input bit chk,
                        input bit swap, input logic [15:0] alt);
    int waits = 0;
    bit done  = 0;
    sb_q.push_back('{exp_data, chk});
    ReadData = rd; WriteData = wr; DataAddr = addr; DataOut = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clock);
      if (DataWaitreq) begin
        waits++;
        @(posedge Clock); #1;
        if (swap) begin
          DataAddr = alt;
          DataOut  = ~wd;
        end
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got no completion for addr %h expected one", addr);
    end
    check("wait_cycles", 16'(waits), 16'(exp_waits));
    @(posedge Clock); #1;
  endtask

  task automatic idle();
    ReadData = 1'b0; WriteData = 1'b0;
  endtask

  task automatic do_reset(input int n);
    idle();
    Reset = 1'b1;
    repeat (n) @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  task automatic main_seq();
    // Reset with a request present: it must be ignored.
    Reset = 1'b1; ReadData = 1'b1; WriteData = 1'b0; DataAddr = 16'h0010; DataOut = 16'h0000;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_waitreq", 16'(DataWaitreq), 16'h0);
    check("reset_datain", DataIn, 16'h0000);
    check("reset_buserror", 16'(BusError), 16'h0);
    check("reset_stall", StallCount, 16'h0000);
    @(posedge Clock); #1;
    Reset = 1'b0; idle();
    @(posedge Clock); #1;
    check("idle_after_reset_stall", StallCount, 16'h0000);

    access(0, 1, 16'h0010, 16'hBEEF, 1, 16'h0, 0, 0, 16'h0);
    access(1, 0, 16'h0010, 16'h0000, 2, 16'hBEEF, 1, 0, 16'h0);
    check("stall_after_read", StallCount, 16'd3);

    // Write then read with no bubble.
    access(0, 1, 16'h0020, 16'h1234, 1, 16'h0, 0, 0, 16'h0);
    access(1, 0, 16'h0020, 16'h0000, 2, 16'h1234, 1, 0, 16'h0);

    access(0, 1, 16'h0005, 16'h5555, 1, 16'h0, 0, 0, 16'h0);
    access(0, 1, 16'h0001, 16'h1111, 1, 16'h0, 0, 0, 16'h0);
    access(0, 1, 16'h0002, 16'h2222, 1, 16'h0, 0, 0, 16'h0);
    // Address changes to 0x0002 during WAIT; latched 0x0001 must be used.
    access(1, 0, 16'h0001, 16'h0000, 2, 16'h1111, 1, 1, 16'h0002);
    check("buserror_clean", 16'(BusError), 16'h0);

    access(1, 0, 16'h1000, 16'h0000, 2, 16'h0000, 1, 0, 16'h0);
    check("buserror_unmapped", 16'(BusError), 16'h1);
    access(0, 1, 16'h1005, 16'h9999, 1, 16'h0, 0, 0, 16'h0);
    access(1, 0, 16'h0005, 16'h0000, 2, 16'h5555, 1, 0, 16'h0);
    check("buserror_sticky", 16'(BusError), 16'h1);
    idle();

    do_reset(2);
    check("buserror_cleared", 16'(BusError), 16'h0);
    access(1, 1, 16'h0020, 16'hFFFF, 0, 16'h0, 0, 0, 16'h0);
    idle();
    check("buserror_illegal", 16'(BusError), 16'h1);
    check("stall_illegal", StallCount, 16'h0000);
    access(1, 0, 16'h0020, 16'h0000, 2, 16'h1234, 1, 0, 16'h0);

    // Reset lands on the DONE cycle of a write: it must not be committed.
    ReadData = 1'b0; WriteData = 1'b1; DataAddr = 16'h0005; DataOut = 16'hAAAA;
    @(negedge Clock);
    check("abort_waitreq_req", 16'(DataWaitreq), 16'h1);
    @(posedge Clock); #1;
    Reset = 1'b1; idle();
    @(posedge Clock); #1;
    check("abort_datain", DataIn, 16'h0000);
    check("abort_waitreq", 16'(DataWaitreq), 16'h0);
    check("abort_buserror", 16'(BusError), 16'h0);
    check("abort_stall", StallCount, 16'h0000);
    Reset = 1'b0;
    @(posedge Clock); #1;
    access(1, 0, 16'h0005, 16'h0000, 2, 16'h5555, 1, 0, 16'h0);
    idle();
    repeat (2) @(posedge Clock);
  endtask

  task automatic sat_seq();
    s_Reset = 1'b1; s_ReadData = 1'b0; s_WriteData = 1'b0;
    s_DataAddr = 16'h0000; s_DataOut = 16'h0000;
    repeat (2) @(posedge Clock);
    #1 s_Reset = 1'b0; s_ReadData = 1'b1;
    repeat (15) @(posedge Clock);
    @(negedge Clock);
    check("sat_first_done_waitreq", 16'(s_DataWaitreq), 16'h0);
    check("sat_first_stall", s_StallCount, 16'd15);
    repeat (70000) @(posedge Clock);
    @(negedge Clock);
    check("sat_stall", s_StallCount, 16'hFFFF);
    s_ReadData = 1'b0;
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    check("scoreboard_drained", 16'(sb_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
